ram_hex_dumper: RTL and testbench
=================================

Name: ram_hex_dumper

Overview:
- Synthesizable engine that walks a RAM address range through a ram_dump-style read port and streams it out as Intel HEX ASCII text, one byte per transfer, with valid/ready backpressure.
- Successor to the simulation-only dump task; parametrised in data width and address width.
- Adds extended linear address (type 04) records for images larger than 64 KiB, a runtime start address and word count, and backpressured output.
- Sits between the RAM override port and a UART TX or debug FIFO; the system asserts override before pulsing start.

Parameters:
- ADDR_W, 32: byte-address width. Legal range 16..32.
- DATA_BYTES, 4: bytes per RAM word; also the data-record length LL. Legal values 1, 2, 4, 8.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a dump; ignored while busy=1.
- start_addr  in  ADDR_W  first byte address; must be DATA_BYTES-aligned; sampled on start.
- word_count  in  ADDR_W  number of words to read; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the EOF record's final byte is accepted.
- maddr  out  ADDR_W  memory byte address.
- mren  out  1  memory read enable.
- mwait  in  1  memory stall.
- mload  in  8*DATA_BYTES  read data.
- tx_data  out  8  ASCII character.
- tx_valid  out  1  character valid.
- tx_ready  in  1  sink accepts.

Behaviour:
- Reset values: every output is 0. This includes busy, done, mren, maddr, tx_valid and tx_data. Reset mid-dump aborts immediately; the partial record is not completed.
- States: IDLE, READ, ELA, DATA, EOF, FIN.
- IDLE: on start, latch addr=start_addr, remaining=word_count, ela_hi=0, then go to READ. If word_count=0, go to EOF instead.
- READ: drive maddr=addr and mren=1, both stable until a rising edge with mwait=0. Capture mload on that edge and drop mren the next cycle.
  - If SKIP_ZERO_EN skips the word, advance without emitting anything.
  - Otherwise, if addr[ADDR_W-1:16] != ela_hi, go to ELA; else go to DATA.
- ELA: emit ":02000004HHHHCC\n" with HHHH = addr[31:16] (upper bits zero-extended when ADDR_W<32). Set ela_hi to that value, then go to DATA.
- DATA: emit ":" LL AAAA "00" data CC "\n".
  - LL = DATA_BYTES.
  - AAAA = addr[15:0].
  - Data is printed most-significant byte first.
- After DATA, or after a skipped word:
  - addr += DATA_BYTES, wrapping modulo 2^ADDR_W.
  - remaining -= 1.
  - If remaining=0, go to EOF; else go to READ.
- EOF: emit ":00000001FF\n", then go to FIN.
- FIN: pulse done for one cycle, then return to IDLE.
- Character encoding: all hex digits are uppercase ASCII. The line terminator is a single 0x0A.
- Checksum CC = (0x100 - sum of all record bytes, i.e. LL, address bytes, type and data) mod 256.
- Output handshake:
  - A character transfers on a rising edge with tx_valid&tx_ready.
  - tx_data is held stable while tx_valid&!tx_ready.
  - tx_valid never drops without a transfer, except on reset.
  - Sustained rate is one character per cycle while tx_ready=1.
- The running checksum is accumulated while bytes are emitted; no second pass over the data.
- An address wrap past 0xFFFF_FFFF causes a fresh ELA record when the upper bits change.
- start while busy has no effect.

Optional Feature:
- SKIP_ZERO_EN defined: a word with mload==0 produces no record and does not update ela_hi. Its read still occurs, and it still counts toward word_count.
- SKIP_ZERO_EN undefined: every word produces a data record.

Decomposition:
- Package hex_dump_pkg contains:
  - dump_state_t enum.
  - Record-type constants HEX_REC_DATA=8'h00, HEX_REC_EOF=8'h01, HEX_REC_ELA=8'h04.
  - ASCII constants ':' and LF.
  - Function nibble_to_ascii.
- Sub-module hex_record_emitter is natural. It takes type, address, payload and length, and serialises one record (characters plus checksum) onto the tx handshake. The top level keeps the FSM and the memory port.

Test Plan:
- start_addr=0, word_count=2, memory {0x00000013, 0xDEADBEEF}, tx_ready=1 -> stream ":0400000000000013E9\n:04000400DEADBEEFC0\n:00000001FF\n", then one done pulse.
- start_addr=0x0001_0000, word_count=1, data 0x00000013 -> ":020000040001F9\n" precedes ":0400000000000013E9\n", then EOF.
- word_count=0 -> only ":00000001FF\n"; mren never asserted.
- mwait held high 5 cycles on each read and tx_ready toggled pseudo-randomly -> identical character sequence, no dropped or duplicated characters, maddr/mren and tx_data stable while stalled.
- SKIP_ZERO_EN defined, memory {0, 0x00000013, 0} with word_count=3 -> exactly one data record, ":0400040000000013E5\n", then EOF.
- Assert rst mid-record -> all outputs 0 asynchronously; a following start produces a complete, correct dump.

Source files
------------

// File: rtl/hex_dump_pkg.sv
// ============================================================================
// Module  : hex_dump_pkg
// Purpose : Shared types, Intel HEX record constants and ASCII helpers.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hex_dump_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_ELA  = 3'd2,
        S_DATA = 3'd3,
        S_EOF  = 3'd4,
        S_FIN  = 3'd5
    } dump_state_t;

    localparam logic [7:0] HEX_REC_DATA = 8'h00;
    localparam logic [7:0] HEX_REC_EOF  = 8'h01;
    localparam logic [7:0] HEX_REC_ELA  = 8'h04;

    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

`default_nettype wire

// File: rtl/hex_record_emitter.sv
// ============================================================================
// Module  : hex_record_emitter
// Purpose : Serialises one Intel HEX record (colon, bytes, checksum, LF) onto
//           a valid/ready character stream, accumulating the checksum inline.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_record_emitter #(
    parameter int PAY_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             rec_type,
    input  logic [15:0]            rec_addr,
    input  logic [8*PAY_BYTES-1:0] payload,
    input  logic [3:0]             len,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   rec_done
);
    import hex_dump_pkg::*;

    localparam logic [1:0] c_PH_IDLE  = 2'd0;
    localparam logic [1:0] c_PH_COLON = 2'd1;
    localparam logic [1:0] c_PH_BYTES = 2'd2;
    localparam logic [1:0] c_PH_LF    = 2'd3;

    logic [1:0]             r_ph;
    logic [3:0]             r_idx;
    logic                   r_lo;
    logic [7:0]             r_sum;
    logic [7:0]             r_type;
    logic [15:0]            r_addr;
    logic [8*PAY_BYTES-1:0] r_payload;
    logic [3:0]             r_len;

    logic       w_fire;
    logic       w_cks_byte;
    logic [3:0] w_sel;
    logic [7:0] w_byte;

    assign w_fire     = (r_ph != c_PH_IDLE) && tx_ready;
    assign w_cks_byte = (r_idx == (4'd4 + r_len));
    // Payload is printed MSB first: byte index 4 maps to payload byte len-1.
    assign w_sel      = r_len + 4'd3 - r_idx;

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            4'd0:    w_byte = {4'h0, r_len};
            4'd1:    w_byte = r_addr[15:8];
            4'd2:    w_byte = r_addr[7:0];
            4'd3:    w_byte = r_type;
            default: begin
                if (w_cks_byte) begin
                    w_byte = 8'h00 - r_sum;
                end else begin
                    for (int k = 0; k < PAY_BYTES; k++) begin
                        if (w_sel == 4'(k)) w_byte = r_payload[8*k +: 8];
                    end
                end
            end
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        case (r_ph)
            c_PH_COLON: tx_data = ASCII_COLON;
            c_PH_BYTES: tx_data = nibble_to_ascii(r_lo ? w_byte[3:0] : w_byte[7:4]);
            c_PH_LF:    tx_data = ASCII_LF;
            default:    tx_data = 8'h00;
        endcase
    end

    assign tx_valid = (r_ph != c_PH_IDLE);
    assign rec_done = (r_ph == c_PH_LF) && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ph      <= c_PH_IDLE;
            r_idx     <= 4'd0;
            r_lo      <= 1'b0;
            r_sum     <= 8'h00;
            r_type    <= 8'h00;
            r_addr    <= 16'h0000;
            r_payload <= '0;
            r_len     <= 4'd0;
        end else begin
            case (r_ph)
                c_PH_IDLE: begin
                    if (start) begin
                        r_ph      <= c_PH_COLON;
                        r_idx     <= 4'd0;
                        r_lo      <= 1'b0;
                        r_sum     <= 8'h00;
                        r_type    <= rec_type;
                        r_addr    <= rec_addr;
                        r_payload <= payload;
                        r_len     <= len;
                    end
                end
                c_PH_COLON: if (w_fire) r_ph <= c_PH_BYTES;
                c_PH_BYTES: begin
                    if (w_fire) begin
                        r_lo <= ~r_lo;
                        if (r_lo) begin
                            r_sum <= r_sum + w_byte;
                            if (w_cks_byte) r_ph <= c_PH_LF;
                            else            r_idx <= r_idx + 4'd1;
                        end
                    end
                end
                default: if (w_fire) r_ph <= c_PH_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_hex_dumper.sv
// ============================================================================
// Module  : ram_hex_dumper
// Purpose : Walks a RAM range and streams it as Intel HEX text with ELA
//           records. Optional macro SKIP_ZERO_EN suppresses all-zero words.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_hex_dumper #(
    parameter int ADDR_W     = 32,
    parameter int DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_addr,
    input  logic [ADDR_W-1:0]       word_count,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       maddr,
    output logic                    mren,
    input  logic                    mwait,
    input  logic [8*DATA_BYTES-1:0] mload,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready
);
    import hex_dump_pkg::*;

    localparam int c_PAY_BYTES = (DATA_BYTES < 2) ? 2 : DATA_BYTES;
    localparam int c_PW        = 8 * c_PAY_BYTES;
    localparam int c_DW        = 8 * DATA_BYTES;

    dump_state_t       r_state, w_next;
    logic [ADDR_W-1:0] r_addr, r_remaining;
    logic [15:0]       r_ela_hi;
    logic [c_DW-1:0]   r_word;
    logic              r_issued;

    logic              w_skip, w_rd_ok, w_last, w_advance;
    logic [15:0]       w_addr_hi;
    logic              w_em_start, w_em_done;
    logic [7:0]        w_em_type;
    logic [15:0]       w_em_addr;
    logic [c_PW-1:0]   w_em_payload;
    logic [3:0]        w_em_len;

`ifdef SKIP_ZERO_EN
    assign w_skip = (mload == '0);
`else
    assign w_skip = 1'b0;
`endif

    assign w_addr_hi = 16'(r_addr >> 16);
    assign w_rd_ok   = (r_state == S_READ) && !mwait;
    assign w_last    = (r_remaining == ADDR_W'(1));
    assign w_advance = (w_rd_ok && w_skip) || ((r_state == S_DATA) && w_em_done);
    assign maddr     = r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = (word_count == '0) ? S_EOF : S_READ;
            S_READ: begin
                if (!mwait) begin
                    if (w_skip)                     w_next = w_last ? S_EOF : S_READ;
                    else if (w_addr_hi != r_ela_hi) w_next = S_ELA;
                    else                            w_next = S_DATA;
                end
            end
            S_ELA:   if (w_em_done) w_next = S_DATA;
            S_DATA:  if (w_em_done) w_next = w_last ? S_EOF : S_READ;
            S_EOF:   if (w_em_done) w_next = S_FIN;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_FIN);
        mren         = (r_state == S_READ);
        w_em_start   = ((r_state == S_ELA) || (r_state == S_DATA) || (r_state == S_EOF))
                       && !r_issued;
        w_em_type    = HEX_REC_EOF;
        w_em_addr    = 16'h0000;
        w_em_payload = '0;
        w_em_len     = 4'd0;
        case (r_state)
            S_ELA: begin
                w_em_type    = HEX_REC_ELA;
                w_em_payload = c_PW'(w_addr_hi);
                w_em_len     = 4'd2;
            end
            S_DATA: begin
                w_em_type    = HEX_REC_DATA;
                w_em_addr    = r_addr[15:0];
                w_em_payload = c_PW'(r_word);
                w_em_len     = 4'(DATA_BYTES);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_ela_hi    <= 16'h0000;
            r_word      <= '0;
            r_issued    <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_addr      <= start_addr;
                r_remaining <= word_count;
                r_ela_hi    <= 16'h0000;
            end
            if (w_rd_ok) r_word <= mload;
            if ((r_state == S_ELA) && w_em_done) r_ela_hi <= w_addr_hi;
            if (w_advance) begin
                r_addr      <= r_addr + ADDR_W'(DATA_BYTES);
                r_remaining <= r_remaining - ADDR_W'(1);
            end
            // One record launch per ELA/DATA/EOF visit; rearmed when it completes.
            if (w_em_done)       r_issued <= 1'b0;
            else if (w_em_start) r_issued <= 1'b1;
        end
    end

    hex_record_emitter #(
        .PAY_BYTES (c_PAY_BYTES)
    ) u_emitter (
        .clk      (clk),
        .rst      (rst),
        .start    (w_em_start),
        .rec_type (w_em_type),
        .rec_addr (w_em_addr),
        .payload  (w_em_payload),
        .len      (w_em_len),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rec_done (w_em_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_ram_hex_dumper.sv
// ============================================================================
// Module  : tb_ram_hex_dumper
// Purpose : Directed self-checking bench for ram_hex_dumper (LF shown as '/').
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_hex_dumper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] start_addr = 32'h0;
    logic [31:0] word_count = 32'h0;
    logic        busy, done, mren, mwait;
    logic [31:0] maddr, mload;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;

    int    errors = 0;
    int    checks = 0;
    string rx = "";
    int    done_cnt = 0, mren_cnt = 0, stab_err = 0, stall_cnt = 0;
    bit    stall_en = 1'b0, rnd_en = 1'b0;
    logic [31:0] mem [4];

    logic       pv = 1'b0, pr = 1'b0, pm = 1'b0, pw = 1'b0;
    logic [7:0] pd = 8'h0;
    logic [31:0] pa = 32'h0;

    ram_hex_dumper #(.ADDR_W(32), .DATA_BYTES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .maddr      (maddr),
        .mren       (mren),
        .mwait      (mwait),
        .mload      (mload),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    assign mload = mem[maddr[3:2]];
    assign mwait = stall_en && mren && (stall_cnt < 5);

    function automatic string vis(input logic [7:0] c);
        if (c == 8'h0A) return "/";
        if (c < 8'h20 || c > 8'h7E) return "?";
        return $sformatf("%c", c);
    endfunction

    always @(posedge clk) begin
        stall_cnt <= (mren && mwait) ? stall_cnt + 1 : 0;
        if (done) done_cnt <= done_cnt + 1;
        if (mren) mren_cnt <= mren_cnt + 1;
        if (tx_valid && tx_ready) rx <= {rx, vis(tx_data)};
    end

    always @(posedge clk) begin
        #2;
        tx_ready = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Held-output monitor: a stalled character or read must not move.
    always @(negedge clk) begin
        if (!rst) begin
            if (pv && !pr && (!tx_valid || tx_data != pd)) stab_err <= stab_err + 1;
            if (pm && pw && (!mren || maddr != pa))        stab_err <= stab_err + 1;
        end
        pv <= tx_valid && !rst;
        pr <= tx_ready;
        pd <= tx_data;
        pm <= mren && !rst;
        pw <= mwait;
        pa <= maddr;
    end

    task automatic chk(input string tag, input string got, input string exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", tag, got, exp);
        end
    endtask

    task automatic run_dump(input string tag, input logic [31:0] a, input logic [31:0] wc,
                            input string exp, input bit poke);
        int base, d0, n;
        bit seen;
        @(negedge clk);
        base = rx.len();
        d0   = done_cnt;
        start = 1'b1; start_addr = a; word_count = wc;
        @(negedge clk);
        start = 1'b0; start_addr = 32'h0001_0000; word_count = 32'd7;
        chk({tag, "_busy"}, $sformatf("%0b", busy), "1");
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 3000) begin
            @(negedge clk);
            n++;
            if (poke && n == 20) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                n++;
            end
            if (done) seen = 1'b1;
        end
        chk({tag, "_timeout"}, seen ? "done" : "timeout", "done");
        repeat (3) @(negedge clk);
        chk({tag, "_stream"}, rx.substr(base, rx.len() - 1), exp);
        chk({tag, "_donecnt"}, $sformatf("%0d", done_cnt - d0), "1");
        chk({tag, "_idle"}, $sformatf("%0b", busy), "0");
    endtask

    localparam string c_T1  = ":0400000000000013E9/:04000400DEADBEEFC0/:00000001FF/";
    localparam string c_EOF = ":00000001FF/";

    initial begin
        int m0, base, n;
        mem[0] = 32'h0000_0013; mem[1] = 32'hDEAD_BEEF;
        mem[2] = 32'h0;         mem[3] = 32'h0;

        #12;
        chk("reset_outs", $sformatf("%0b%0b%0b%0h%0b%0h", busy, done, mren, maddr, tx_valid, tx_data),
            "000000");
        @(negedge clk);
        rst = 1'b0;

        run_dump("basic", 32'h0, 32'd2, c_T1, 1'b0);
        run_dump("ela", 32'h0001_0000, 32'd1,
                 {":020000040001F9/:0400000000000013E9/", c_EOF}, 1'b0);

        m0 = mren_cnt;
        run_dump("zero", 32'h0, 32'd0, c_EOF, 1'b0);
        chk("zero_mren", $sformatf("%0d", mren_cnt - m0), "0");

        stall_en = 1'b1; rnd_en = 1'b1;
        run_dump("stall", 32'h0, 32'd2, c_T1, 1'b1);
        stall_en = 1'b0; rnd_en = 1'b0;
        chk("stall_stable", $sformatf("%0d", stab_err), "0");

        mem[0] = 32'h0; mem[1] = 32'h0000_0013; mem[2] = 32'h0;
`ifdef SKIP_ZERO_EN
        run_dump("skip", 32'h0, 32'd3, {":0400040000000013E5/", c_EOF}, 1'b0);
`else
        run_dump("skip", 32'h0, 32'd3,
                 {":0400000000000000FC/:0400040000000013E5/:0400080000000000F4/", c_EOF}, 1'b0);
`endif

        mem[0] = 32'h0000_0013; mem[3] = 32'h1122_3344;
        run_dump("wrap", 32'hFFFF_FFFC, 32'd2,
                 {":02000004FFFFFC/:04FFFC001122334457/:020000040000FA/:0400000000000013E9/", c_EOF},
                 1'b0);

        mem[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        base = rx.len();
        start = 1'b1; start_addr = 32'h0000_0100; word_count = 32'd2;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (rx.len() < base + 25 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach", (rx.len() >= base + 25) ? "mid" : "timeout", "mid");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", $sformatf("%0b%0b%0b%0h%0b%0h", busy, done, mren, maddr, tx_valid, tx_data),
            "000000");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_dump("after_rst", 32'h0, 32'd2, c_T1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
